offchip_mem_ctrl: RTL and testbench



---
 rtl/offchip_mem_ctrl_pkg.sv | 20 ++
 rtl/offchip_mem_ctrl_rr_arb2.sv | 32 +++
 rtl/offchip_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_offchip_mem_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/offchip_mem_ctrl_pkg.sv
// Shared configuration and types for the off-chip memory line initiator.
// Defaults mirror the CPU-wide line size and address width.
package offchip_mem_ctrl_pkg;

    localparam int DEF_CACHE_LINE_SIZE = 16;
    localparam int DEF_MAX_BIT_POS     = 31;
    localparam int DEF_TIMEOUT_CYCLES  = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

endpackage

// File: rtl/offchip_mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side not granted last time wins.
module rr_arb2
    import offchip_mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_ic,
    input  logic i_req_dc,
    input  logic i_accept,
    output logic o_grant_dc
);

    grant_t r_last_grant;

    always_comb begin
        o_grant_dc = 1'b0;
        if (i_req_dc && !i_req_ic)
            o_grant_dc = 1'b1;
        else if (i_req_ic && !i_req_dc)
            o_grant_dc = 1'b0;
        else
            o_grant_dc = (r_last_grant == GNT_IC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= GNT_IC;
        else if (i_accept)
            r_last_grant <= o_grant_dc ? GNT_DC : GNT_IC;
    end

endmodule

// File: rtl/offchip_mem_ctrl.sv
// Cache-line initiator: arbitrates icache/dcache line requests onto the level-held
// off-chip memory port, one transfer outstanding, with an optional ready timeout.
module offchip_mem_ctrl
    import offchip_mem_ctrl_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = DEF_CACHE_LINE_SIZE,
    parameter int ADDR_WIDTH      = DEF_MAX_BIT_POS + 1,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ic_req,
    input  logic [ADDR_WIDTH-1:0]        ic_addr,
    output logic [CACHE_LINE_SIZE*8-1:0] ic_rdata,
    output logic                         ic_done,
    input  logic                         dc_req,
    input  logic                         dc_we,
    input  logic [ADDR_WIDTH-1:0]        dc_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0] dc_wdata,
    output logic [CACHE_LINE_SIZE*8-1:0] dc_rdata,
    output logic                         dc_done,
    output logic                         err,
    output logic                         offchip_mem_read_en,
    output logic                         offchip_mem_write_en,
    output logic [ADDR_WIDTH-1:0]        offchip_mem_addr,
    output logic [CACHE_LINE_SIZE*8-1:0] offchip_mem_wdata,
    input  logic [CACHE_LINE_SIZE*8-1:0] offchip_mem_data,
    input  logic                         offchip_mem_ready
);

    localparam int LW = CACHE_LINE_SIZE * 8;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(CACHE_LINE_SIZE - 1);

    state_t                r_state;
    logic                  r_owner_dc;
    logic                  r_we;
    logic [TW-1:0]         r_tmo;
    logic                  r_read_en;
    logic                  r_write_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]         r_wdata;
    logic [LW-1:0]         r_ic_rdata;
    logic [LW-1:0]         r_dc_rdata;
    logic                  r_ic_done;
    logic                  r_dc_done;
    logic                  r_err;

    logic w_grant_dc;
    logic w_accept;
    logic w_tmo_hit;

    assign w_accept  = (r_state == ST_IDLE) && (ic_req || dc_req);
    // Fires on the REQ cycle whose increment would reach TIMEOUT_CYCLES.
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_ic   (ic_req),
        .i_req_dc   (dc_req),
        .i_accept   (w_accept),
        .o_grant_dc (w_grant_dc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner_dc <= 1'b0;
            r_we       <= 1'b0;
            r_tmo      <= '0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ic_rdata <= '0;
            r_dc_rdata <= '0;
            r_ic_done  <= 1'b0;
            r_dc_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ic_done <= 1'b0;
            r_dc_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_accept) begin
                        r_owner_dc <= w_grant_dc;
                        r_we       <= w_grant_dc && dc_we;
                        r_addr     <= (w_grant_dc ? dc_addr : ic_addr) & ~LINE_MASK;
                        if (w_grant_dc && dc_we) begin
                            r_wdata    <= dc_wdata;
                            r_write_en <= 1'b1;
                        end else begin
                            r_read_en  <= 1'b1;
                        end
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (offchip_mem_ready) begin
                        r_read_en  <= 1'b0;
                        r_write_en <= 1'b0;
                        if (r_owner_dc) begin
                            r_dc_done <= 1'b1;
                            if (!r_we)
                                r_dc_rdata <= offchip_mem_data;
                        end else begin
                            r_ic_done  <= 1'b1;
                            r_ic_rdata <= offchip_mem_data;
                        end
                        r_state <= ST_RELEASE;
                    end else if (w_tmo_hit) begin
                        r_read_en  <= 1'b0;
                        r_write_en <= 1'b0;
                        r_err      <= 1'b1;
                        if (r_owner_dc) begin
                            r_dc_done  <= 1'b1;
                            r_dc_rdata <= '0;
                        end else begin
                            r_ic_done  <= 1'b1;
                            r_ic_rdata <= '0;
                        end
                        r_state <= ST_RELEASE;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    r_tmo <= '0;
                    if (!offchip_mem_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ic_rdata             = r_ic_rdata;
    assign ic_done              = r_ic_done;
    assign dc_rdata             = r_dc_rdata;
    assign dc_done              = r_dc_done;
    assign err                  = r_err;
    assign offchip_mem_read_en  = r_read_en;
    assign offchip_mem_write_en = r_write_en;
    assign offchip_mem_addr     = r_addr;
    assign offchip_mem_wdata    = r_wdata;

endmodule

// File: tb/tb_offchip_mem_ctrl.sv
// Directed, table-driven bench for offchip_mem_ctrl with hand sequences for
// reset-time ties, long ready and reset in the middle of a request.
module tb_offchip_mem_ctrl;

    localparam int LW = 128;
    localparam int AW = 32;

    logic          clk, rst;
    logic          ic_req, dc_req, dc_we;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, ic_rdata, dc_rdata;
    logic          ic_done, dc_done, err;
    logic          mem_rd, mem_wr, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_data;

    int checks   = 0;
    int failures = 0;

    offchip_mem_ctrl #(.CACHE_LINE_SIZE(16), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ic_req               (ic_req),
        .ic_addr              (ic_addr),
        .ic_rdata             (ic_rdata),
        .ic_done              (ic_done),
        .dc_req               (dc_req),
        .dc_we                (dc_we),
        .dc_addr              (dc_addr),
        .dc_wdata             (dc_wdata),
        .dc_rdata             (dc_rdata),
        .dc_done              (dc_done),
        .err                  (err),
        .offchip_mem_read_en  (mem_rd),
        .offchip_mem_write_en (mem_wr),
        .offchip_mem_addr     (mem_addr),
        .offchip_mem_wdata    (mem_wdata),
        .offchip_mem_data     (mem_data),
        .offchip_mem_ready    (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          ic_req;
        logic [AW-1:0] ic_addr;
        logic          dc_req;
        logic          dc_we;
        logic [AW-1:0] dc_addr;
        logic [LW-1:0] dc_wdata;
        int            delay;
        int            len;
        logic [LW-1:0] mdata;
        logic          exp_dc;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {mem_rd, mem_wr, ic_done, dc_done, err}, '0);
        chk({tag, "_addr"}, mem_addr, '0);
        chk({tag, "_wdata"}, mem_wdata, '0);
        chk({tag, "_ic_rdata"}, ic_rdata, '0);
        chk({tag, "_dc_rdata"}, dc_rdata, '0);
    endtask

    // Wait for the enable, model the responder, and check the completion.
    task automatic serve(input string tag, input logic exp_dc, input logic exp_we,
                         input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_wdata,
                         input int delay, input int len, input logic [LW-1:0] mdata,
                         input logic [LW-1:0] exp_rdata, input logic exp_err);
        int n;
        int en_cycles;
        n = 0;
        while (!(mem_rd || mem_wr) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rd_en"}, mem_rd, !exp_we);
        chk({tag, "_wr_en"}, mem_wr, exp_we);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        if (exp_we)
            chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        en_cycles = 1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (mem_rd || mem_wr)
                en_cycles++;
        end
        if (len > 0) begin
            mem_ready = 1'b1;
            mem_data  = mdata;
        end
        @(negedge clk);
        chk({tag, "_en_cycles"}, en_cycles, delay + 1);
        chk({tag, "_done"}, {ic_done, dc_done}, exp_dc ? 2'b01 : 2'b10);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_rdata"}, exp_dc ? dc_rdata : ic_rdata, exp_rdata);
        chk({tag, "_en_drop"}, {mem_rd, mem_wr}, 2'b00);
        if (exp_dc) dc_req = 1'b0;
        else        ic_req = 1'b0;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            chk({tag, "_long_ready_quiet"}, {ic_done, dc_done, mem_rd, mem_wr}, 4'b0000);
        end
        mem_ready = 1'b0;
        mem_data  = '0;
    endtask

    initial begin
        logic [LW-1:0] d1, d2, d3, d4, d5, d6, d7, a5, f5, c3, junk;
        d1   = 128'h0F0E0D0C0B0A09080706050403020100;
        d2   = 128'h0123456789ABCDEFFEDCBA9876543210;
        d3   = {4{32'h11112222}};
        d4   = {4{32'h33334444}};
        d5   = {4{32'h55556666}};
        d6   = {4{32'h77778888}};
        d7   = 128'hFFEEDDCCBBAA99887766554433221100;
        a5   = {16{8'hA5}};
        f5   = {16{8'h5A}};
        c3   = {16{8'h3C}};
        junk = {4{32'hCAFEF00D}};

        //          ic  ic_addr        dc  we  dc_addr        dc_wdata dly len mdata exp_dc we  exp_addr      rdata err
        tv[0]  = '{1'b1, 32'h0000_0047, 1'b0, 1'b0, 32'h0,        '0,  3, 1, d1,   1'b0, 1'b0, 32'h0000_0040, d1,  1'b0};
        tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h1234_567F, '0, 0, 1, d2,   1'b1, 1'b0, 32'h1234_5670, d2,  1'b0};
        tv[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0080, a5, 2, 1, junk, 1'b1, 1'b1, 32'h0000_0080, d2,  1'b0};
        tv[3]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_020F, '0, 1, 1, d3,   1'b0, 1'b0, 32'h0000_0100, d3,  1'b0};
        tv[4]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_020F, '0, 1, 1, d4,   1'b1, 1'b0, 32'h0000_0200, d4,  1'b0};
        tv[5]  = '{1'b1, 32'h0000_031F, 1'b1, 1'b1, 32'h0000_02A0, f5, 1, 1, d5,   1'b0, 1'b0, 32'h0000_0310, d5,  1'b0};
        tv[6]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_02A0, f5, 4, 2, junk, 1'b1, 1'b1, 32'h0000_02A0, d4,  1'b0};
        tv[7]  = '{1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0,        '0,  1, 3, d6,   1'b0, 1'b0, 32'h0000_0400, d6,  1'b0};
        tv[8]  = '{1'b1, 32'h0000_0505, 1'b0, 1'b0, 32'h0,        '0,  7, 0, junk, 1'b0, 1'b0, 32'h0000_0500, '0,  1'b1};
        tv[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_09C3, c3, 7, 0, junk, 1'b1, 1'b1, 32'h0000_09C0, '0,  1'b1};
        tv[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, '0, 6, 1, d7,   1'b1, 1'b0, 32'hFFFF_FFF0, d7,  1'b0};

        rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_ready = 1'b0; mem_data = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            ic_req   = tv[i].ic_req;
            ic_addr  = tv[i].ic_addr;
            dc_req   = tv[i].dc_req;
            dc_we    = tv[i].dc_we;
            dc_addr  = tv[i].dc_addr;
            dc_wdata = tv[i].dc_wdata;
            serve($sformatf("v%0d", i), tv[i].exp_dc, tv[i].exp_we, tv[i].exp_addr, tv[i].dc_wdata,
                  tv[i].delay, tv[i].len, tv[i].mdata, tv[i].exp_rdata, tv[i].exp_err);
            ic_req = 1'b0;
            dc_req = 1'b0;
            @(negedge clk);
        end

        // Tie straight out of reset: dcache first (held over a 2-cycle ready), then icache.
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all_zero("rst2");
        @(negedge clk);
        rst = 1'b0;
        ic_req = 1'b1; ic_addr = 32'h0000_0700;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_07A4;
        serve("tie_dc", 1'b1, 1'b0, 32'h0000_07A0, '0, 1, 2, d3, d3, 1'b0);
        @(negedge clk);
        chk("tie_gap_en_low", {mem_rd, mem_wr}, 2'b00);
        serve("tie_ic", 1'b0, 1'b0, 32'h0000_0700, '0, 0, 1, d5, d5, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Reset while read_en is high: outputs clear at once, held req is re-served.
        ic_req = 1'b1; ic_addr = 32'h0000_060C;
        for (int n = 0; n < 20 && !mem_rd; n++)
            @(negedge clk);
        chk("midreq_en_before", mem_rd, 1'b1);
        rst = 1'b1;
        #1 chk_all_zero("midreq_rst");
        @(negedge clk);
        chk("midreq_no_done", {ic_done, dc_done}, 2'b00);
        rst = 1'b0;
        serve("midreq_retry", 1'b0, 1'b0, 32'h0000_0600, '0, 0, 1, d6, d6, 1'b0);
        ic_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("final_idle", {mem_rd, mem_wr, ic_done, dc_done}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
